// File: rtl/maxpool_window_sequencer_pkg.sv
// Shared widths, FSM encoding and pool-unit handshake constants
// for the max-pool window sequencer.
package maxpool_window_sequencer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DIM_WIDTH  = 8;

  // Samples reach the pool unit one cycle after the RAM read strobe.
  localparam int PU_SAMPLE_LAT  = 1;
  localparam int PU_CLEAR_LEN   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/maxpool_window_sequencer_addr_gen.sv
// Window/kernel counters plus input and output RAM address arithmetic
// for the max-pool window sequencer.
module maxpool_addr_gen
  import maxpool_window_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  step_k,
  input  logic                  step_w,
  input  logic [DIM_WIDTH-1:0]  n,
  input  logic [DIM_WIDTH-1:0]  k,
  input  logic [DIM_WIDTH-1:0]  s,
  input  logic [DIM_WIDTH-1:0]  m,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  last_sample,
  output logic                  last_window
);

  localparam logic [DIM_WIDTH-1:0] ONE = 1;

  logic [DIM_WIDTH-1:0] orow_q, orow_d;
  logic [DIM_WIDTH-1:0] ocol_q, ocol_d;
  logic [DIM_WIDTH-1:0] kr_q, kr_d;
  logic [DIM_WIDTH-1:0] kc_q, kc_d;
  logic [ADDR_WIDTH-1:0] row_a, col_a;

  assign last_sample = (kr_q == k - ONE) && (kc_q == k - ONE);
  assign last_window = (orow_q == m - ONE) && (ocol_q == m - ONE);

  always_comb begin
    orow_d = orow_q;
    ocol_d = ocol_q;
    kr_d   = kr_q;
    kc_d   = kc_q;
    if (init) begin
      orow_d = '0;
      ocol_d = '0;
      kr_d   = '0;
      kc_d   = '0;
    end else begin
      if (step_k) begin
        if (kc_q == k - ONE) begin
          kc_d = '0;
          kr_d = (kr_q == k - ONE) ? '0 : kr_q + ONE;
        end else begin
          kc_d = kc_q + ONE;
        end
      end
      if (step_w) begin
        if (ocol_q == m - ONE) begin
          ocol_d = '0;
          orow_d = orow_q + ONE;
        end else begin
          ocol_d = ocol_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      orow_q <= '0;
      ocol_q <= '0;
      kr_q   <= '0;
      kc_q   <= '0;
    end else begin
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      kr_q   <= kr_d;
      kc_q   <= kc_d;
    end
  end

  // Everything wraps modulo 2^ADDR_WIDTH.
  assign row_a = ADDR_WIDTH'(orow_q) * ADDR_WIDTH'(s)
               + ADDR_WIDTH'(kr_q);
  assign col_a = ADDR_WIDTH'(ocol_q) * ADDR_WIDTH'(s)
               + ADDR_WIDTH'(kc_q);
  assign rd_addr = in_base + row_a * ADDR_WIDTH'(n) + col_a;
  assign wr_addr = out_base
                 + ADDR_WIDTH'(orow_q) * ADDR_WIDTH'(m)
                 + ADDR_WIDTH'(ocol_q);

endmodule

// File: rtl/maxpool_window_sequencer.sv
// Walks pooling windows over one channel: issues reads, feeds the
// fp16 max-pool unit and writes each window result to output RAM.
module maxpool_window_sequencer
  import maxpool_window_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   cfg_fm_size,
  input  logic [DIM_WIDTH-1:0]   cfg_pool_size,
  input  logic [DIM_WIDTH-1:0]   cfg_stride,
  input  logic [ADDR_WIDTH-1:0]  cfg_in_base,
  input  logic [ADDR_WIDTH-1:0]  cfg_out_base,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_error,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   pu_clear,
  output logic                   pu_valid,
  output logic [DATA_WIDTH-1:0]  pu_data,
  output logic [DIM_WIDTH*2-1:0] pu_count,
  input  logic                   pu_result_ready,
  input  logic [DATA_WIDTH-1:0]  pu_result,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data
);

  localparam int CW = DIM_WIDTH * 2;
  localparam logic [DIM_WIDTH-1:0] ONE = 1;

  state_e state_q, state_d;
  logic [DIM_WIDTH-1:0]  n_q, n_d, k_q, k_d;
  logic [DIM_WIDTH-1:0]  s_q, s_d, m_q, m_d;
  logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
  logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
  logic busy_q, busy_d, done_q, done_d;
  logic cfg_error_q, cfg_error_d;
  logic pu_clear_q, pu_clear_d;
  logic rd_en_q, rd_en_d, pu_valid_q, pu_valid_d;
  logic wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic init, step_k, step_w;
  logic last_sample, last_window, illegal;

  assign illegal = (cfg_pool_size == '0) || (cfg_stride == '0)
                || (cfg_pool_size > cfg_fm_size);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    s_d         = s_q;
    m_d         = m_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_error_d = cfg_error_q;
    pu_clear_d  = 1'b0;
    rd_en_d     = rd_en_q;
    pu_valid_d  = rd_en_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    init        = 1'b0;
    step_k      = 1'b0;
    step_w      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d         = cfg_fm_size;
          k_d         = cfg_pool_size;
          s_d         = cfg_stride;
          in_base_d   = cfg_in_base;
          out_base_d  = cfg_out_base;
          cfg_error_d = illegal;
          if (illegal) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETUP;
            busy_d  = 1'b1;
          end
        end
      end
      S_SETUP: begin
        m_d        = (n_q - k_q) / s_q + ONE;
        init       = 1'b1;
        pu_clear_d = 1'b1;
        state_d    = S_CLEAR;
      end
      S_CLEAR: begin
        rd_en_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        step_k = 1'b1;
        if (last_sample) begin
          rd_en_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pu_result_ready) begin
          wr_en_d   = 1'b1;
          wr_data_d = pu_result;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        step_w = 1'b1;
        if (last_window) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          pu_clear_d = 1'b1;
          state_d    = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      s_q         <= '0;
      m_q         <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;
      pu_clear_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      pu_valid_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      s_q         <= s_d;
      m_q         <= m_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_error_q <= cfg_error_d;
      pu_clear_q  <= pu_clear_d;
      rd_en_q     <= rd_en_d;
      pu_valid_q  <= pu_valid_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
    end
  end

  maxpool_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .step_k      (step_k),
    .step_w      (step_w),
    .n           (n_q),
    .k           (k_q),
    .s           (s_q),
    .m           (m_q),
    .in_base     (in_base_q),
    .out_base    (out_base_q),
    .rd_addr     (rd_addr),
    .wr_addr     (wr_addr),
    .last_sample (last_sample),
    .last_window (last_window)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_error = cfg_error_q;
  assign rd_en     = rd_en_q;
  assign pu_clear  = pu_clear_q;
  assign pu_valid  = pu_valid_q;
  // RAM data lines up with the delayed strobe; zero when idle.
  assign pu_data   = pu_valid_q ? rd_data : '0;
  assign pu_count  = CW'(k_q) * CW'(k_q);
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Directed bench: RAM and pool-unit models, checks on writes, reads,
// handshakes, illegal configs, stalls, reset abort and address wrap.
module tb_maxpool_window_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_fm_size = '0;
  logic [7:0]  cfg_pool_size = '0;
  logic [7:0]  cfg_stride = '0;
  logic [15:0] cfg_in_base = '0;
  logic [15:0] cfg_out_base = '0;
  logic        busy, done, cfg_error;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic        pu_clear, pu_valid;
  logic [15:0] pu_data;
  logic [15:0] pu_count;
  logic        pu_result_ready;
  logic [15:0] pu_result = '0;
  logic        wr_en;
  logic [15:0] wr_addr, wr_data;

  logic pool_rdy = 1'b0;
  logic spur_rdy = 1'b0;
  assign pu_result_ready = pool_rdy | spur_rdy;

  int checks = 0;
  int failures = 0;

  logic [15:0] rd_q[$];
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  int done_cnt = 0;
  int busy_viol = 0;
  int d0 = 0;
  int win_idx = 0;
  int stall_win = -1;

  logic [15:0] pm_max = '0;
  int pm_cnt = 0;
  int pm_wait = 0;
  bit pm_arm = 1'b0;

  maxpool_window_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_fm_size     (cfg_fm_size),
    .cfg_pool_size   (cfg_pool_size),
    .cfg_stride      (cfg_stride),
    .cfg_in_base     (cfg_in_base),
    .cfg_out_base    (cfg_out_base),
    .busy            (busy),
    .done            (done),
    .cfg_error       (cfg_error),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .pu_clear        (pu_clear),
    .pu_valid        (pu_valid),
    .pu_data         (pu_data),
    .pu_count        (pu_count),
    .pu_result_ready (pu_result_ready),
    .pu_result       (pu_result),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data)
  );

  always #5 clk = ~clk;

  // Input RAM holds its own address as data.
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr;
  end

  always @(negedge clk) begin
    if (rd_en) rd_q.push_back(rd_addr);
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      if (!busy) busy_viol++;
    end
    if (done) done_cnt++;
    if (done && busy) busy_viol++;
  end

  // Pool unit: max of K*K samples, result a few cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      pm_max = '0;
      pm_cnt = 0;
      pm_arm = 1'b0;
      pool_rdy = 1'b0;
    end else begin
      pool_rdy = 1'b0;
      if (pu_clear) begin
        pm_max = '0;
        pm_cnt = 0;
      end
      if (pm_arm) begin
        pm_wait--;
        if (pm_wait == 0) begin
          pool_rdy = 1'b1;
          pm_arm = 1'b0;
        end
      end
      if (pu_valid) begin
        if (pu_data > pm_max) pm_max = pu_data;
        pm_cnt++;
        if (pm_cnt == int'(pu_count)) begin
          pu_result = pm_max;
          pm_wait = (win_idx == stall_win) ? 20 : 2;
          pm_arm = 1'b1;
          win_idx++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] n, input logic [7:0] k,
                     input logic [7:0] s, input logic [15:0] ib,
                     input logic [15:0] ob);
    cfg_fm_size   = n;
    cfg_pool_size = k;
    cfg_stride    = s;
    cfg_in_base   = ib;
    cfg_out_base  = ob;
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    win_idx = 0;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
    chk("done_seen", done_cnt != d0, 1'b1);
  endtask

  task automatic chk_basic_writes(input string tag);
    logic [15:0] exp_d[4];
    exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
    chk({tag, "_wcount"}, wa_q.size(), 4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk({tag, "_waddr"}, wa_q[i], 16'h100 + 16'(i));
      chk({tag, "_wdata"}, wd_q[i], exp_d[i]);
    end
  endtask

  initial begin
    int r0, w0, dc;
    logic [15:0] ea;
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_outs",
        {busy, done, cfg_error, rd_en, rd_addr, pu_clear, pu_valid,
         pu_data, pu_count, wr_en, wr_addr, wr_data}, '0);
    rst = 1'b1;
    tick();

    // Basic 2x2 window, stride 2.
    run(8'd4, 8'd2, 8'd2, 16'h0000, 16'h0100);
    chk("t1_busy", busy, 1'b1);
    chk("t1_pu_count", pu_count, 16'd4);
    wait_done();
    repeat (3) tick();
    chk_basic_writes("t1");
    chk("t1_reads", rd_q.size(), 16);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_busy_viol", busy_viol, 0);
    chk("t1_idle", {busy, done}, 2'b00);

    // Overlapping 3x3 windows, stride 1.
    run(8'd5, 8'd3, 8'd1, 16'h0000, 16'h0040);
    wait_done();
    repeat (3) tick();
    chk("t2_reads", rd_q.size(), 81);
    dc = 0;
    for (int orow = 0; orow < 3; orow++)
      for (int ocol = 0; ocol < 3; ocol++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++) begin
            ea = 16'((orow + kr) * 5 + ocol + kc);
            if (dc < rd_q.size()) chk("t2_rd_order", rd_q[dc], ea);
            dc++;
          end
    chk("t2_wcount", wa_q.size(), 9);
    for (int i = 0; i < 9 && i < wa_q.size(); i++) begin
      chk("t2_waddr", wa_q[i], 16'h40 + 16'(i));
      chk("t2_wdata", wd_q[i],
          16'((i / 3 + 2) * 5 + (i % 3) + 2));
    end
    chk("t2_done_once", done_cnt - d0, 1);

    // Illegal: K > N.
    rd_q.delete();
    wa_q.delete();
    cfg_fm_size = 8'd4;
    cfg_pool_size = 8'd5;
    cfg_stride = 8'd1;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e1_done", {done, cfg_error, busy}, 3'b110);
    tick();
    chk("e1_after", {done, cfg_error, busy}, 3'b010);
    repeat (3) tick();
    chk("e1_no_ram", rd_q.size() + wa_q.size(), 0);
    chk("e1_done_once", done_cnt - d0, 1);

    // Illegal: stride 0.
    cfg_pool_size = 8'd2;
    cfg_stride = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e2_done", {done, cfg_error, busy}, 3'b110);
    repeat (3) tick();
    chk("e2_no_ram", rd_q.size() + wa_q.size(), 0);

    // Legal start clears the error; window 2 stalls in WAIT.
    stall_win = 1;
    run(8'd4, 8'd2, 8'd2, 16'h0000, 16'h0100);
    chk("s_err_clr", {cfg_error, busy}, 2'b01);
    for (int i = 0; i < 500 && win_idx < 2; i++) tick();
    chk("s_reach", win_idx >= 2, 1'b1);
    r0 = rd_q.size();
    w0 = wa_q.size();
    repeat (15) tick();
    chk("s_no_reads", rd_q.size(), r0);
    chk("s_no_writes", wa_q.size(), w0);
    chk("s_state", {busy, rd_en, wr_en}, 3'b100);
    wait_done();
    stall_win = -1;
    repeat (2) tick();
    chk_basic_writes("s");
    chk("s_reads", rd_q.size(), 16);

    // Spurious result strobe while idle.
    w0 = wa_q.size();
    dc = done_cnt;
    spur_rdy = 1'b1;
    tick();
    spur_rdy = 1'b0;
    repeat (3) tick();
    chk("spur_idle",
        {32'(wa_q.size() - w0), 32'(done_cnt - dc), busy}, '0);

    // Reset during ISSUE of window 3.
    run(8'd4, 8'd2, 8'd2, 16'h0000, 16'h0100);
    for (int i = 0; i < 500 && !(wa_q.size() == 2 && rd_en); i++)
      tick();
    chk("r_reach", {32'(wa_q.size()), rd_en}, {32'd2, 1'b1});
    dc = done_cnt;
    rst = 1'b0;
    #1;
    chk("r_outs",
        {busy, done, cfg_error, rd_en, rd_addr, pu_clear, pu_valid,
         pu_data, pu_count, wr_en, wr_addr, wr_data}, '0);
    repeat (3) tick();
    chk("r_no_done", done_cnt - dc, 0);
    rst = 1'b1;
    tick();
    run(8'd4, 8'd2, 8'd2, 16'h0000, 16'h0100);
    wait_done();
    repeat (2) tick();
    chk_basic_writes("r");
    chk("r_first_rd", rd_q.size() > 0 ? rd_q[0] : 16'hDEAD, 16'h0);

    // Input address wraps past 0xFFFF.
    run(8'd2, 8'd2, 8'd1, 16'hFFFE, 16'h0200);
    wait_done();
    repeat (2) tick();
    chk("w_reads", rd_q.size(), 4);
    if (rd_q.size() == 4)
      chk("w_rd_seq", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]},
          {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
    chk("w_wcount", wa_q.size(), 1);
    if (wa_q.size() == 1)
      chk("w_write", {wa_q[0], wd_q[0]}, {16'h0200, 16'hFFFF});
    chk("final_busy_viol", busy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
